// File: rtl/mdu_iter_div.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their *W variants.
// One quotient bit per CALC cycle; sign fix-up and word sign-extension happen in FIX.
module mdu_iter_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sign,
    input  logic            shorten,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [CW-1:0]   counter;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r;
    logic            neg_q, neg_r, shorten_r;

    function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
        return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    // Operand preparation for the accept cycle
    logic [XLEN-1:0] ext_dvd, ext_dvs, abs_dvd, abs_dvs, min_neg;
    logic            dvd_neg, dvs_neg, div_zero, overflow;

    always_comb begin
        ext_dvd = dividend;
        ext_dvs = divisor;
        if (shorten) begin
            ext_dvd = sign ? sext_half(dividend) : {{HALF{1'b0}}, dividend[HALF-1:0]};
            ext_dvs = sign ? sext_half(divisor)  : {{HALF{1'b0}}, divisor[HALF-1:0]};
        end
        // after extension bit XLEN-1 mirrors bit HALF-1 for signed word ops
        dvd_neg  = sign & ext_dvd[XLEN-1];
        dvs_neg  = sign & ext_dvs[XLEN-1];
        abs_dvd  = dvd_neg ? -ext_dvd : ext_dvd;
        abs_dvs  = dvs_neg ? -ext_dvs : ext_dvs;
        min_neg  = shorten ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (ext_dvs == '0);
        overflow = sign && (ext_dvd == min_neg) && (ext_dvs == '1);
    end

    // One restoring step: shift {rem, quo} left and trial-subtract the divisor
    logic [XLEN:0]   shifted, trial;
    logic            no_borrow;

    always_comb begin
        shifted   = {rem_r, quo_r[XLEN-1]};
        trial     = shifted - {1'b0, dvs_r};
        no_borrow = ~trial[XLEN];
    end

    logic [XLEN-1:0] fix_q, fix_r;

    always_comb begin
        fix_q = neg_q ? -quo_r : quo_r;
        fix_r = neg_r ? -rem_r : rem_r;
        if (shorten_r) begin
            fix_q = sext_half(fix_q);
            fix_r = sext_half(fix_r);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            counter   <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            shorten_r <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shorten_r <= shorten;
                        neg_q     <= dvd_neg ^ dvs_neg;
                        neg_r     <= dvd_neg;
                        dvs_r     <= abs_dvs;
                        rem_r     <= '0;
                        // word dividends start in the upper half so 32 shifts drain them
                        quo_r     <= shorten ? {abs_dvd[HALF-1:0], {HALF{1'b0}}} : abs_dvd;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= shorten ? sext_half(dividend) : dividend;
                            state     <= S_DONE;
                        end else if (overflow) begin
                            quotient  <= ext_dvd;
                            remainder <= '0;
                            state     <= S_DONE;
                        end else begin
                            counter <= shorten ? CW'(HALF) : CW'(XLEN);
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (no_borrow) begin
                        rem_r <= trial[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b0};
                    end
                    counter <= counter - 1'b1;
                    if (counter == CW'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    quotient  <= fix_q;
                    remainder <= fix_r;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule
